// File: rtl/frame_buffer_packed.sv
// frame_buffer_packed: packed-word pixel frame buffer; clk/reset, wr_valid/wr_ready/wr_address/write_data unpack P pixels upper-first, rd_address->read_data 1-cycle read, sticky overflow_err, swap_req/front_bank double buffering under FRAME_BUFFER_DOUBLE_BUFFER_EN
module frame_buffer_packed #(
  parameter int PIXEL_W = 9,
  parameter int PIXELS_PER_WORD = 2,
  parameter int DEPTH = 307200,
  parameter int ADDR_W = 19
)(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_W-1:0]                  wr_address,
  input  logic [PIXEL_W*PIXELS_PER_WORD-1:0] write_data,
  input  logic [ADDR_W-1:0]                  rd_address,
  output logic [PIXEL_W-1:0]                 read_data,
  output logic                               overflow_err,
  input  logic                               swap_req,
  output logic                               front_bank
);
  localparam int P = PIXELS_PER_WORD;
  localparam int IDX_W = $clog2(P) + 1;
`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif
  localparam int MEM_AW = $clog2(BANKS * DEPTH);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  typedef enum logic {IDLE, UNPACK} state_t;
  state_t state, state_nx;
  logic [PIXEL_W*P-1:0] word_q;
  logic [ADDR_W-1:0] ptr, wa, first_ptr;
  logic [IDX_W-1:0] idx;
  logic [PIXEL_W-1:0] wd;
  logic [PIXEL_W-1:0] mem [BANKS*DEPTH];
  logic [MEM_AW-1:0] wa_m, ra_m;
  logic accept, we, wr_bank, rd_bank;
  assign wr_ready = state == IDLE && !reset;
  assign accept = wr_valid && wr_ready;
  assign first_ptr = ADDR_W'(({1'b0, wr_address} + (ADDR_W+1)'(1)) % DEPTH_V);
  assign wr_bank = BANKS == 2 && !front_bank;
  assign rd_bank = BANKS == 2 && front_bank;
  assign wa_m = MEM_AW'(wa) + (wr_bank ? MEM_AW'(DEPTH) : '0);
  assign ra_m = MEM_AW'(rd_address) + (rd_bank ? MEM_AW'(DEPTH) : '0);
  always_comb begin
    state_nx = state;
    we = 1'b0;
    wa = wr_address;
    wd = write_data[PIXEL_W*P-1 -: PIXEL_W];
    if (state == IDLE) begin
      we = accept && {1'b0, wr_address} < DEPTH_V;
      state_nx = accept && P > 1 ? UNPACK : IDLE;
    end else begin
      we = !reset;
      wa = ptr;
      wd = word_q[(P-1-int'(idx))*PIXEL_W +: PIXEL_W];
      state_nx = int'(idx) == P-1 ? IDLE : UNPACK;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      overflow_err <= 1'b0;
      read_data <= '0;
    end else begin
      state <= state_nx;
      overflow_err <= overflow_err || (accept && {1'b0, wr_address} >= DEPTH_V);
      read_data <= {1'b0, rd_address} < DEPTH_V ? mem[ra_m] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= write_data;
      ptr <= first_ptr;
      idx <= IDX_W'(1);
    end else if (state == UNPACK) begin
      ptr <= ptr == ADDR_W'(DEPTH-1) ? '0 : ptr + ADDR_W'(1);
      idx <= idx + IDX_W'(1);
    end
    if (we) mem[wa_m] <= wd;
  end
`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
  logic swap_pending, swap_go;
  assign swap_go = state == IDLE && !accept && swap_pending;
  always_ff @(posedge clk) begin
    if (reset) begin
      front_bank <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      front_bank <= front_bank ^ swap_go;
      swap_pending <= !swap_go && (swap_pending || swap_req);
    end
  end
`else
  logic unused_swap;
  assign unused_swap = swap_req;
  assign front_bank = 1'b0;
`endif
endmodule

// File: doc/frame_buffer_packed.md
Name: frame_buffer_packed

Overview:
Single-clock, parametrised pixel frame buffer between the capture/drawing logic and the HDMI scan-out reader. Accepts packed write words carrying PIXELS_PER_WORD pixels and unpacks them serially, storing every pixel (upper slice first) at consecutive addresses under a valid/ready handshake. The read port is registered, with fixed 1-cycle latency. An optional second bank provides double buffering with a frame-synchronous swap.

Parameters:
PIXEL_W, 9, bits per stored pixel
PIXELS_PER_WORD, 2, pixels packed per write word (>=1)
DEPTH, 307200, pixels per bank (640x480)
ADDR_W, 19, pixel address width (2**ADDR_W >= DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_valid  input  1  write word offered
wr_ready  output  1  block can accept a word this cycle
wr_address  input  ADDR_W  pixel address of the first (most significant) pixel in the word
write_data  input  PIXEL_W*PIXELS_PER_WORD  packed pixels; slice k = bits [(P-k)*W-1 -: W], k=0 stored first
rd_address  input  ADDR_W  pixel read address
read_data  output  PIXEL_W  registered read pixel
overflow_err  output  1  sticky: a write address was >= DEPTH
swap_req  input  1  request bank swap (used only with DOUBLE_BUFFER_EN)
front_bank  output  1  bank currently being read

Behaviour:
- Reset values: wr_ready=0 while reset is asserted, 1 in the first cycle after release. read_data=0, overflow_err=0, front_bank=0, FSM=IDLE. Memory contents are not cleared.
- FSM states: IDLE and UNPACK.
- IDLE: wr_ready=1. A handshake (wr_valid & wr_ready) does the following in the same cycle:
  - writes slice 0 to wr_address;
  - latches write_data, sets ptr=wr_address+1 and idx=1;
  - goes to UNPACK if PIXELS_PER_WORD>1, else stays in IDLE.
- UNPACK: wr_ready=0. Writes slice idx to ptr each cycle, then increments ptr and idx. After slice P-1 is written, returns to IDLE.
- Throughput and timing: one word per PIXELS_PER_WORD cycles. Back-to-back words are accepted in the first IDLE cycle.
- Address wrap: ptr increments wrap from DEPTH-1 to 0.
- Out-of-range write: a pixel whose address is >= DEPTH (possible only on the first slice) is not written and sets overflow_err. Remaining slices continue at the wrapped address (addr-DEPTH mod DEPTH).
- Read: read_data at cycle n+1 = mem[rd_address sampled at cycle n]. rd_address >= DEPTH returns 0.
- Read/write collision: read and write to the same address in the same cycle returns the old data (read-before-write).
- wr_valid while wr_ready=0: ignored, no state change. The source must hold the word.
- Reset mid-UNPACK: the remaining slices are discarded and already-written pixels stay. The FSM enters IDLE and overflow_err clears.
- Arithmetic: ptr and idx are sized to avoid truncation; idx uses $clog2(PIXELS_PER_WORD)+1 bits.

Optional Feature:
FRAME_BUFFER_DOUBLE_BUFFER_EN
- Defined:
  - Memory is 2*DEPTH pixels. Writes go to back bank (!front_bank) and reads to front bank, bank offset = bank*DEPTH.
  - A swap_req pulse sets swap_pending. The swap executes (front_bank toggles, swap_pending clears) on the first cycle the FSM is in IDLE with no handshake that cycle, so a word's pixels never straddle banks.
  - A swap_req arriving while swap_pending is set is merged.
  - Reset clears swap_pending.
- Undefined:
  - Single bank of DEPTH pixels; swap_req is ignored and front_bank is tied 0.

Test Plan:
- Reset held 3 cycles, then released -> wr_ready=0 during reset and 1 next cycle; read_data=0 and overflow_err=0.
- Write 0x3FE01 at address 10 (W=9, P=2), then read 10 and 11 -> read_data 0x1FF then 0x001, each 1 cycle after its address; wr_ready low for exactly 1 cycle after the accept.
- Write at address 307199 with data 0x00403 -> mem[307199]=0x002, mem[0]=0x003, overflow_err stays 0. A write at address 307200 -> slice 0 dropped, overflow_err=1, slice 1 stored at mem[1].
- Read address 20 while writing 0x155 to address 20 in the same cycle -> old value returned; the read on the next cycle returns 0x155. rd_address=400000 -> read_data=0.
- Assert reset during UNPACK of a word at address 50 -> mem[50] holds the new slice 0, mem[51] is unchanged, FSM is in IDLE after reset.
- With FRAME_BUFFER_DOUBLE_BUFFER_EN defined: swap_req during UNPACK -> front_bank toggles only after that word completes. Data written before the swap is readable at the same rd_address after the swap.
